instruction_fetch_sequencer: RTL

//  Producer side of the instruction-decoder interface. Runs the Miyamii-4000 instruction cycle on the 4-bit ROM bus:
//  - drives the 12-bit fetch address out as nibbles;
//  - reads the OPR and OPA nibbles back;
//  - assembles them into `instruction[7:0]`;
//  - tracks first and second bytes of two-byte instructions with the `is_two_byte` feedback from the decoder.

---
 rtl/miyamii_pkg.sv | 73 +++++++
 rtl/instruction_fetch_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/miyamii_pkg.sv
// ----------------------------------------------------------------------------
// miyamii_pkg
//   Shared definitions for the Miyamii-4000 instruction cycle.
//   - Phase index helpers. A1 is always 0. The M/X phases follow the
//     ADDR_NIBBLES address phases.
//   - PH_* constants for the default build (3 address nibbles, 8-clock cycle).
//   - The NOP opcode.
//   - A two-byte opcode classifier. It models what the decoder reports on
//     is_two_byte.
//   - The record type used to track expected fetch results.
// ----------------------------------------------------------------------------
package miyamii_pkg;

    localparam int DEFAULT_ADDR_NIBBLES = 3;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    // Phase indices as functions of the number of address nibbles n.
    function automatic logic [3:0] ph_m1(input int n);
        return 4'(n);
    endfunction

    function automatic logic [3:0] ph_m2(input int n);
        return 4'(n + 1);
    endfunction

    function automatic logic [3:0] ph_x1(input int n);
        return 4'(n + 2);
    endfunction

    function automatic logic [3:0] ph_x2(input int n);
        return 4'(n + 3);
    endfunction

    function automatic logic [3:0] ph_x3(input int n);
        return 4'(n + 4);
    endfunction

    localparam logic [3:0] PH_A1 = 4'd0;
    localparam logic [3:0] PH_M1 = ph_m1(DEFAULT_ADDR_NIBBLES);
    localparam logic [3:0] PH_M2 = ph_m2(DEFAULT_ADDR_NIBBLES);
    localparam logic [3:0] PH_X1 = ph_x1(DEFAULT_ADDR_NIBBLES);
    localparam logic [3:0] PH_X2 = ph_x2(DEFAULT_ADDR_NIBBLES);
    localparam logic [3:0] PH_X3 = ph_x3(DEFAULT_ADDR_NIBBLES);

    // Upper opcode nibbles (OPR) that start a two-byte instruction.
    typedef enum logic [3:0] {
        OPH_JCN = 4'h1,
        OPH_FIM = 4'h2,   // FIM only when OPA is even (odd OPA is SRC)
        OPH_JUN = 4'h4,
        OPH_JMS = 4'h5,
        OPH_ISZ = 4'h7
    } opr_two_byte_e;

    // 1 when the byte, read as an opcode, begins a two-byte instruction.
    function automatic logic is_two_byte_op(input logic [7:0] op);
        logic two;
        two = 1'b0;
        case (op[7:4])
            OPH_JCN, OPH_JUN, OPH_JMS, OPH_ISZ: two = 1'b1;
            OPH_FIM:                            two = ~op[0];
            default:                            two = 1'b0;
        endcase
        return two;
    endfunction

    // One assembled instruction byte as presented to the decoder.
    typedef struct packed {
        logic [7:0] instr;
        logic       first;
    } fetch_item_t;

endpackage

// File: rtl/instruction_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_fetch_sequencer
//   Producer side of the Miyamii-4000 decoder interface.
//
//   Instruction cycle:
//     Phases run A1..A{N}, then M1, M2, X1, X2, X3. N is ADDR_NIBBLES.
//     A phases: the fetch address is driven LSN first on the 4-bit ROM bus.
//     M1 / M2: the OPR and OPA nibbles are read back.
//     X1: the assembled byte is presented to the decoder.
//     X3: the PC is told to advance.
//   A first/second byte flag follows two-byte instructions, using the
//   decoder's is_two_byte feedback.
//
//   Build option:
//     MIYAMII_FETCH_STALL_EN adds a 'stall' input. While stall is high in X3,
//     the sequencer holds in X3. Without the macro the phase counter
//     free-runs.
//
//   Ports:
//     clk            system clock
//     rst_n          synchronous active-low reset
//     pc_in          fetch address from PC/stack (4*ADDR_NIBBLES bits)
//     data_in        ROM bus read nibble
//     is_two_byte    decoder feedback for the current byte, sampled in X3
//     stall          (MIYAMII_FETCH_STALL_EN only) hold in X3
//     addr_out       address nibble on the ROM bus (0 outside A phases)
//     bus_oe         1 while addr_out is driven (A phases)
//     sync           1 during A1
//     phase          current phase index (A1=0 ... X3=ADDR_NIBBLES+4)
//     instruction    assembled {OPR,OPA} byte, updated entering X1
//     is_first_byte  1 = instruction is an opcode byte, 0 = second byte
//     instr_valid    1 during X1
//     pc_inc_req     1 for one clock in X3 (the clock that leaves X3)
// ----------------------------------------------------------------------------
module instruction_fetch_sequencer
    import miyamii_pkg::*;
#(
    parameter int         ADDR_NIBBLES = 3,
    parameter logic [7:0] RESET_INSTR  = NOP_OPCODE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*ADDR_NIBBLES-1:0] pc_in,
    input  logic [3:0]                data_in,
    input  logic                      is_two_byte,
`ifdef MIYAMII_FETCH_STALL_EN
    input  logic                      stall,
`endif
    output logic [3:0]                addr_out,
    output logic                      bus_oe,
    output logic                      sync,
    output logic [3:0]                phase,
    output logic [7:0]                instruction,
    output logic                      is_first_byte,
    output logic                      instr_valid,
    output logic                      pc_inc_req
);

    localparam logic [3:0] M1_IDX = ph_m1(ADDR_NIBBLES);
    localparam logic [3:0] M2_IDX = ph_m2(ADDR_NIBBLES);
    localparam logic [3:0] X1_IDX = ph_x1(ADDR_NIBBLES);
    localparam logic [3:0] X3_IDX = ph_x3(ADDR_NIBBLES);

    logic [3:0]                phase_q,       phase_d;
    logic [4*ADDR_NIBBLES-1:0] addr_q,        addr_d;
    logic [3:0]                opr_q,         opr_d;
    logic [7:0]                instruction_q, instruction_d;
    logic                      first_q,       first_d;
    logic                      instr_valid_q, instr_valid_d;
    logic                      pc_inc_q,      pc_inc_d;
    logic                      x3_release;
    logic [3:0]                addr_nibble;

    // x3_release is 1 on the clock that leaves X3.
`ifdef MIYAMII_FETCH_STALL_EN
    assign x3_release = ~stall;
`else
    assign x3_release = 1'b1;
`endif

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        phase_d       = phase_q;
        addr_d        = addr_q;
        opr_d         = opr_q;
        instruction_d = instruction_q;
        first_d       = first_q;

        if (phase_q == X3_IDX) begin
            if (x3_release) begin
                phase_d = PH_A1;
                // The address is captured on the edge that enters A1.
                // Every A phase, A1 included, then drives a registered
                // nibble.
                addr_d  = pc_in;
                // A second byte (first_q=0) always returns to opcode
                // tracking, so pairs never chain.
                first_d = ~(first_q & is_two_byte);
            end
        end else begin
            phase_d = phase_q + 4'd1;
        end

        if (phase_q == M1_IDX) begin
            opr_d = data_in;
        end

        // OPA goes straight into the low nibble of the instruction
        // register. The byte changes only on the edge into X1.
        if (phase_q == M2_IDX) begin
            instruction_d = {opr_q, data_in};
        end

        instr_valid_d = (phase_d == X1_IDX);
        pc_inc_d      = (phase_d == X3_IDX);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            phase_q       <= PH_A1;
            addr_q        <= '0;
            opr_q         <= 4'h0;
            instruction_q <= RESET_INSTR;
            first_q       <= 1'b1;
            instr_valid_q <= 1'b0;
            pc_inc_q      <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            addr_q        <= addr_d;
            opr_q         <= opr_d;
            instruction_q <= instruction_d;
            first_q       <= first_d;
            instr_valid_q <= instr_valid_d;
            pc_inc_q      <= pc_inc_d;
        end
    end

    // Select the address nibble for the current A phase.
    always_comb begin
        addr_nibble = 4'h0;
        for (int k = 0; k < ADDR_NIBBLES; k++) begin
            if (phase_q == 4'(k)) begin
                addr_nibble = addr_q[4*k +: 4];
            end
        end
    end

    assign addr_out      = addr_nibble;
    assign bus_oe        = (phase_q < M1_IDX);
    assign sync          = (phase_q == PH_A1);
    assign phase         = phase_q;
    assign instruction   = instruction_q;
    assign is_first_byte = first_q;
    assign instr_valid   = instr_valid_q;
    // pc_inc_q stays high while held in X3. Gating it with the release
    // keeps the request to a single clock.
    assign pc_inc_req    = pc_inc_q & x3_release;

endmodule
